fpmul_arbiter: RTL and testbench

Round-robin scheduler that shares one fixed-latency floating-point multiplier among NUM_REQ neuron requesters in the ANN datapath. It accepts weight/input operand pairs, issues at most one pair per cycle to the multiplier, and tracks each in-flight operation with a tag pipeline matched to the multiplier latency. It returns each product to its originating requester with a one-hot valid. It sits between the per-neuron sequencers and the shared multiplier instance.

---
 rtl/fpmul_arbiter.sv | 110 +++++++++++
 tb/tb_fpmul_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmul_arbiter.sv
// Round-robin scheduler sharing one fixed-latency FP multiplier among NUM_REQ requesters.
// A tag pipeline matched to the multiplier latency routes each product back to its requester.
module fpmul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LAT     = 4,
  parameter int DW      = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*DW-1:0] req_w,
  input  logic [NUM_REQ*DW-1:0] req_x,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [DW-1:0]         mul_opa,
  output logic [DW-1:0]         mul_opb,
  output logic                  mul_start,
  input  logic [DW-1:0]         mul_result,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_data,
  output logic                  busy,
  output logic [31:0]           issue_count
);

  // Handshake: a requester holds req (and its operands) until it sees gnt in the same
  // cycle; gnt is the acceptance. rsp_valid is a one-cycle strobe with no backpressure.

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] id;
  } tag_t;

  logic [IW-1:0]      ptr;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] eligible;
  tag_t               tag_pipe [LAT+1];
  logic               grant_any;
  logic [IW-1:0]      grant_id;
  logic [DW-1:0]      sel_w;
  logic [DW-1:0]      sel_x;
  logic [NUM_REQ-1:0] rsp_onehot;

  assign eligible = req & ~pending;
  assign busy     = |pending;

  // Search order starts just after the last granted index.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rstn && !grant_any && eligible[i] && ((int'(ptr) + off) % NUM_REQ == i)) begin
          grant_any = 1'b1;
          grant_id  = IW'(i);
        end
      end
    end
  end

  always_comb begin
    gnt        = '0;
    rsp_onehot = '0;
    sel_w      = '0;
    sel_x      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i]        = grant_any && (grant_id == IW'(i));
      rsp_onehot[i] = tag_pipe[LAT].valid && (tag_pipe[LAT].id == IW'(i));
      if (grant_id == IW'(i)) begin
        sel_w = req_w[i*DW +: DW];
        sel_x = req_x[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr         <= IW'(NUM_REQ - 1);
      pending     <= '0;
      mul_opa     <= '0;
      mul_opb     <= '0;
      mul_start   <= 1'b0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      issue_count <= '0;
      for (int s = 0; s <= LAT; s++) begin
        tag_pipe[s] <= '0;
      end
    end else begin
      mul_start   <= grant_any;
      tag_pipe[0] <= {grant_any, grant_id};
      for (int s = 1; s <= LAT; s++) begin
        tag_pipe[s] <= tag_pipe[s-1];
      end
      if (grant_any) begin
        ptr         <= grant_id;
        mul_opa     <= sel_w;
        mul_opb     <= sel_x;
        issue_count <= issue_count + 32'd1;
      end
      // The final tag stage lines up with the cycle mul_result is valid.
      rsp_valid <= rsp_onehot;
      if (tag_pipe[LAT].valid) begin
        rsp_data <= mul_result;
      end
      pending <= (pending | gnt) & ~rsp_onehot;
    end
  end

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Randomized bench for fpmul_arbiter: a behavioural round-robin/float model feeds an
// expected-response queue that a separate monitor drains on every rsp_valid.
module tb_fpmul_arbiter;
  localparam int NUM_REQ = 4;
  localparam int LAT     = 4;
  localparam int DW      = 32;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic [NUM_REQ-1:0]    req = '0;
  logic [NUM_REQ*DW-1:0] req_w = '0;
  logic [NUM_REQ*DW-1:0] req_x = '0;
  logic [NUM_REQ-1:0]    gnt;
  logic [DW-1:0]         mul_opa;
  logic [DW-1:0]         mul_opb;
  logic                  mul_start;
  logic [DW-1:0]         mul_result;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [DW-1:0]         rsp_data;
  logic                  busy;
  logic [31:0]           issue_count;

  fpmul_arbiter #(.NUM_REQ(NUM_REQ), .LAT(LAT), .DW(DW)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_w(req_w), .req_x(req_x), .gnt(gnt),
    .mul_opa(mul_opa), .mul_opb(mul_opb), .mul_start(mul_start), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .issue_count(issue_count)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- float helpers (operands restricted so products are exact) ----------------
  function automatic real s2r(input logic [31:0] a);
    logic [63:0] d;
    if (a[30:0] == '0) d = {a[31], 63'd0};
    else d = {a[31], {3'b000, a[30:23]} + 11'd896, a[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    real         p;
    logic [63:0] d;
    logic [10:0] e;
    p = s2r(a) * s2r(b);
    d = $realtobits(p);
    if (d[62:0] == '0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0] e;
    logic [2:0] m;
    e = 8'($urandom_range(100, 154));
    m = 3'($urandom_range(0, 7));
    return {1'($urandom_range(0, 1)), e, m, 20'd0};
  endfunction

  // ---------------- multiplier stand-in with LAT-cycle latency ----------------
  bit          mp_v [LAT];
  logic [DW-1:0] mp_d [LAT];
  always @(posedge clk) begin
    mp_v[0] <= mul_start;
    mp_d[0] <= fmul(mul_opa, mul_opb);
    for (int s = 1; s < LAT; s++) begin
      mp_v[s] <= mp_v[s-1];
      mp_d[s] <= mp_d[s-1];
    end
  end
  assign mul_result = mp_v[LAT-1] ? mp_d[LAT-1] : 32'hDEAD_BEEF;

  // ---------------- scoreboard ----------------
  logic [NUM_REQ+DW-1:0] exp_q[$];
  int                    exp_t_q[$];
  int                    vectors = 0;
  int                    errors = 0;
  bit                    mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  initial begin : monitor
    logic [NUM_REQ+DW-1:0] e;
    int                    t;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rsp_valid != '0) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            t = exp_t_q.pop_front();
            check("rsp_valid", 64'(rsp_valid), 64'(e[DW +: NUM_REQ]));
            check("rsp_data", 64'(rsp_data), 64'(e[DW-1:0]));
            check("rsp_cycle", 64'(cyc), 64'(t));
          end
        end else if (exp_t_q.size() > 0 && exp_t_q[0] <= cyc) begin
          e = exp_q.pop_front();
          t = exp_t_q.pop_front();
          check("rsp_missing", 64'(rsp_valid), 64'(e[DW +: NUM_REQ]));
        end
      end
    end
  end

  // ---------------- reference model state ----------------
  int          m_ptr;
  int          m_busy_until [NUM_REQ];
  logic [31:0] m_count;
  bit          m_prev_v;
  logic [DW-1:0] m_prev_w, m_prev_x;
  logic [DW-1:0] op_w [NUM_REQ];
  logic [DW-1:0] op_x [NUM_REQ];

  task automatic model_reset();
    m_ptr    = NUM_REQ - 1;
    m_count  = '0;
    m_prev_v = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) m_busy_until[i] = 0;
    exp_q.delete();
    exp_t_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic [NUM_REQ-1:0] r, input bit do_reset, output int g);
    int                 c;
    int                 idx;
    logic [NUM_REQ-1:0] exp_gnt;
    bit                 exp_busy;
    @(negedge clk);
    c    = cyc;
    req  = r;
    rstn = !do_reset;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_w[i*DW +: DW] = op_w[i];
      req_x[i*DW +: DW] = op_x[i];
    end
    #1;
    g = -1;
    if (!do_reset) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (m_ptr + k) % NUM_REQ;
        if (g < 0 && r[idx] && c >= m_busy_until[idx]) g = idx;
      end
    end
    exp_gnt = '0;
    if (g >= 0) exp_gnt[g] = 1'b1;
    exp_busy = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) if (m_busy_until[i] > c) exp_busy = 1'b1;
    check("gnt", 64'(gnt), 64'(exp_gnt));
    check("busy", 64'(busy), 64'(exp_busy));
    check("issue_count", 64'(issue_count), 64'(m_count));
    check("mul_start", 64'(mul_start), 64'(m_prev_v));
    if (m_prev_v) begin
      check("mul_opa", 64'(mul_opa), 64'(m_prev_w));
      check("mul_opb", 64'(mul_opb), 64'(m_prev_x));
    end
    if (do_reset) begin
      @(posedge clk);
      model_reset();
    end else begin
      m_prev_v = (g >= 0);
      if (g >= 0) begin
        m_ptr           = g;
        m_busy_until[g] = c + LAT + 2;
        m_count         = m_count + 32'd1;
        m_prev_w        = op_w[g];
        m_prev_x        = op_x[g];
        exp_q.push_back({exp_gnt, fmul(op_w[g], op_x[g])});
        exp_t_q.push_back(c + LAT + 2);
      end
    end
  endtask

  task automatic idle(input int n);
    int g;
    for (int i = 0; i < n; i++) drive_cycle('0, 1'b0, g);
  endtask

  task automatic hold_until_granted(input logic [NUM_REQ-1:0] r);
    int g;
    int n;
    n = 0;
    while (r != '0 && n < 50) begin
      drive_cycle(r, 1'b0, g);
      if (g >= 0) r[g] = 1'b0;
      n++;
    end
    if (r != '0) check("grant_timeout", 64'(r), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int                 g;
    bit                 rst;
    logic [NUM_REQ-1:0] want;
    for (int i = 0; i < NUM_REQ; i++) begin
      op_w[i] = rand_op();
      op_x[i] = rand_op();
    end
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    model_reset();
    mon_en = 1'b1;

    // single request: 2.0 * 3.0
    op_w[0] = 32'h4000_0000;
    op_x[0] = 32'h4040_0000;
    drive_cycle(4'b0001, 1'b0, g);
    idle(LAT + 3);

    // all four together
    hold_until_granted(4'b1111);
    idle(LAT + 3);

    // requester 1 held continuously across its pending window
    for (int i = 0; i < 2 * (LAT + 2) + 1; i++) drive_cycle(4'b0010, 1'b0, g);
    idle(LAT + 3);

    // round-robin after last grant to 2
    drive_cycle(4'b0100, 1'b0, g);
    hold_until_granted(4'b1011);
    idle(LAT + 3);

    // reset mid-flight
    hold_until_granted(4'b0011);
    drive_cycle('0, 1'b1, g);
    idle(LAT + 3);
    drive_cycle(4'b1111, 1'b0, g);
    idle(LAT + 3);

    // counter wrap
    idle(1);
    force dut.issue_count = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.issue_count;
    drive_cycle(4'b0100, 1'b0, g);
    idle(LAT + 3);

    // randomized traffic with occasional resets
    want = '0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!want[i] && $urandom_range(0, 99) < 40) begin
          want[i] = 1'b1;
          op_w[i] = rand_op();
          op_x[i] = rand_op();
        end
      end
      rst = ($urandom_range(0, 199) == 0);
      drive_cycle(want, rst, g);
      if (rst) begin
        want = '0;
      end else if (g >= 0) begin
        want[g] = ($urandom_range(0, 3) == 0);
        op_w[g] = rand_op();
        op_x[g] = rand_op();
      end
    end
    idle(LAT + 4);
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
